banco_registradores_param: RTL

BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

---
 rtl/banco_registradores_param.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/banco_registradores_param.sv
// -----------------------------------------------------------------------------
// banco_registradores_param
//
// Parameterised register file with two banks:
//   - a data bank of NREG registers, each DATA_W bits wide
//   - a boolean bank of NBOOL 1-bit registers
// Each bank has two synchronous read ports and one write port. Read results
// are registered, so they appear one clock edge after the address is presented.
//
// Optional feature (compile-time macro):
//   BANCO_BYPASS_EN  - when defined, a read that targets the register being
//                      written in the same cycle returns the new write value.
//                      This applies per port and per bank. When undefined,
//                      such a read returns the value held before the write.
//
// Parameters:
//   DATA_W   width of each data register
//   NREG     number of data registers (power of two, >= 2)
//   NBOOL    number of boolean registers (power of two, >= 2)
//   ZERO_R0  when 1, data register 0 always reads as zero and ignores writes
//
// Ports:
//   Clock            single clock, rising edge
//   Reset_n          synchronous active-low reset; has priority over Halt and
//                    over any write
//   Halt             freezes all register and output state while high; writes
//                    presented during Halt are dropped
//   RegLido1/2       data read addresses
//   RegEscrito       data write address
//   EscreveReg       data write enable
//   DadoEscrito      data write value
//   BoolLido1/2      boolean read addresses
//   BoolEscrito      boolean write address
//   EscreveBool      boolean write enable
//   DadoBoolEscrito  boolean write value
//   Dado1/2          registered data read results
//   DadoBool1/2      registered boolean read results
// -----------------------------------------------------------------------------
module banco_registradores_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NREG    = 8,
    parameter int unsigned NBOOL   = 4,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      Halt,
    input  logic [$clog2(NREG)-1:0]   RegLido1,
    input  logic [$clog2(NREG)-1:0]   RegLido2,
    input  logic [$clog2(NREG)-1:0]   RegEscrito,
    input  logic                      EscreveReg,
    input  logic [DATA_W-1:0]         DadoEscrito,
    input  logic [$clog2(NBOOL)-1:0]  BoolLido1,
    input  logic [$clog2(NBOOL)-1:0]  BoolLido2,
    input  logic [$clog2(NBOOL)-1:0]  BoolEscrito,
    input  logic                      EscreveBool,
    input  logic                      DadoBoolEscrito,
    output logic [DATA_W-1:0]         Dado1,
    output logic [DATA_W-1:0]         Dado2,
    output logic                      DadoBool1,
    output logic                      DadoBool2
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned BW = $clog2(NBOOL);

    // Storage
    logic [DATA_W-1:0] banco     [NREG];
    logic              bancoBool [NBOOL];

    // Qualified write strobes
    logic              regWrEn;
    logic              boolWrEn;

    // Next values for the registered read outputs
    logic [DATA_W-1:0] proxDado1;
    logic [DATA_W-1:0] proxDado2;
    logic              proxBool1;
    logic              proxBool2;

    // Register 0 is hard-wired to zero when ZERO_R0 is set.
    function automatic logic ehZero(input logic [AW-1:0] addr);
        return (ZERO_R0 != 0) && (addr == AW'(0));
    endfunction

    // Write qualification: a write to the zero register is discarded.
    always_comb begin
        regWrEn  = EscreveReg && !ehZero(RegEscrito);
        boolWrEn = EscreveBool;
    end

    // Data bank read path, with optional same-cycle forwarding.
    always_comb begin
        proxDado1 = banco[RegLido1];
        proxDado2 = banco[RegLido2];
`ifdef BANCO_BYPASS_EN
        if (regWrEn && (RegEscrito == RegLido1)) begin
            proxDado1 = DadoEscrito;
        end
        if (regWrEn && (RegEscrito == RegLido2)) begin
            proxDado2 = DadoEscrito;
        end
`endif
        // Zero register wins over storage and forwarding alike.
        if (ehZero(RegLido1)) begin
            proxDado1 = '0;
        end
        if (ehZero(RegLido2)) begin
            proxDado2 = '0;
        end
    end

    // Boolean bank read path, with optional same-cycle forwarding.
    always_comb begin
        proxBool1 = bancoBool[BoolLido1];
        proxBool2 = bancoBool[BoolLido2];
`ifdef BANCO_BYPASS_EN
        if (boolWrEn && (BoolEscrito == BoolLido1)) begin
            proxBool1 = DadoBoolEscrito;
        end
        if (boolWrEn && (BoolEscrito == BoolLido2)) begin
            proxBool2 = DadoBoolEscrito;
        end
`endif
    end

    // Data bank storage: reset clears everything, Halt freezes it.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                banco[i] <= '0;
            end
        end else if (!Halt) begin
            if (regWrEn) begin
                banco[RegEscrito] <= DadoEscrito;
            end
        end
    end

    // Boolean bank storage: reset clears everything, Halt freezes it.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NBOOL); i++) begin
                bancoBool[i] <= 1'b0;
            end
        end else if (!Halt) begin
            if (boolWrEn) begin
                bancoBool[BoolEscrito] <= DadoBoolEscrito;
            end
        end
    end

    // Registered read outputs; they hold their value while Halt is high.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Dado1     <= '0;
            Dado2     <= '0;
            DadoBool1 <= 1'b0;
            DadoBool2 <= 1'b0;
        end else if (!Halt) begin
            Dado1     <= proxDado1;
            Dado2     <= proxDado2;
            DadoBool1 <= proxBool1;
            DadoBool2 <= proxBool2;
        end
    end

endmodule
